// File: rtl/serial_parallel.sv
// MSB-first serial-to-parallel converter with a holding register so the next
// word can shift in while the previous one waits downstream.
module serial_parallel #(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  clock_enable,
   input  logic                  clear,
   input  logic                  serial_in_valid,
   output logic                  serial_in_ready,
   input  logic                  serial_in,
   output logic                  parallel_out_valid,
   input  logic                  parallel_out_ready,
   output logic [WORD_WIDTH-1:0] parallel_out
);

   localparam int COUNT_WIDTH = $clog2(WORD_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(WORD_WIDTH - 1);

   logic [WORD_WIDTH-1:0]  shift_reg, shift_next;
   logic [COUNT_WIDTH-1:0] count_reg, count_next;
   logic [WORD_WIDTH-1:0]  out_reg, out_next;
   logic                   valid_reg, valid_next;

   logic [WORD_WIDTH-1:0]  shifted_word;
   logic                   at_last_bit;
   logic                   accept;
   logic                   complete;
   logic                   drain;

   // Shift toward the MSB; the incoming bit enters at bit 0.
   assign shifted_word[0] = serial_in;
   generate
      for (genvar gi = 1; gi < WORD_WIDTH; gi++) begin : g_shift
         assign shifted_word[gi] = shift_reg[gi-1];
      end
   endgenerate

   assign at_last_bit = (count_reg == LAST_BIT);

   // Only the word-completing bit waits, and only while the holding register
   // is full and not draining; this is a deliberate combinational path.
   assign serial_in_ready = clock_enable &
                            ~(at_last_bit & valid_reg & ~parallel_out_ready);

   assign accept   = serial_in_valid & serial_in_ready;
   assign complete = accept & at_last_bit;
   assign drain    = valid_reg & parallel_out_ready & clock_enable;

   always_comb begin
      shift_next = shift_reg;
      count_next = count_reg;
      out_next   = out_reg;
      valid_next = valid_reg;
      if (clear) begin
         shift_next = '0;
         count_next = '0;
         out_next   = '0;
         valid_next = 1'b0;
      end else if (clock_enable) begin
         if (accept) begin
            shift_next = shifted_word;
            count_next = at_last_bit ? '0 : count_reg + COUNT_WIDTH'(1);
         end
         // A completion wins over a drain so back-to-back words see no bubble.
         if (complete) begin
            out_next   = shifted_word;
            valid_next = 1'b1;
         end else if (drain) begin
            valid_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         shift_reg <= '0;
         count_reg <= '0;
         out_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         shift_reg <= shift_next;
         count_reg <= count_next;
         out_reg   <= out_next;
         valid_reg <= valid_next;
      end
   end

   assign parallel_out       = out_reg;
   assign parallel_out_valid = valid_reg;

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
- Serial-to-parallel converter: the receiving end of a MSB-first bit-serial stream.
- Accepts one bit per ready/valid handshake into a shift register and counts WORD_WIDTH bits.
- Transfers each completed word into an output holding register, presented with a ready/valid handshake.
- The holding register lets the next word shift in while the previous one waits downstream, so a continuous bit stream has no gaps unless the output backpressures.

Parameters:
- WORD_WIDTH, 8: bits per parallel word; legal values are 2 or more.
- COUNT_WIDTH, clog2(WORD_WIDTH): width of the bit counter; derived localparam, not user-set.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously externally.
- clock_enable  in  1  when low, all state holds and no handshake completes.
- clear  in  1  synchronous active-high flush; ignores clock_enable.
- serial_in_valid  in  1  a bit is offered on serial_in.
- serial_in_ready  out  1  bit can be accepted this cycle (combinational).
- serial_in  in  1  serial data bit; first bit of a word is the MSB.
- parallel_out_valid  out  1  holding register contains an unread word (registered).
- parallel_out_ready  in  1  downstream takes the word.
- parallel_out  out  WORD_WIDTH  completed word (registered).

Behaviour:
- Reset (clear_n low, asynchronous): shift register = 0, count = 0, parallel_out = 0, parallel_out_valid = 0. serial_in_ready is combinational, so it equals clock_enable while in reset.
- Priority order: clear_n, then clear, then clock_enable, then normal operation.
- clear: on the next edge, shift register, count, parallel_out and parallel_out_valid go to their reset values. Any partial word and any unread word are discarded.
- serial accept = serial_in_valid & serial_in_ready.
  - On accept: shift register <= {shift register[W-2:0], serial_in}.
  - If count != W-1, count increments by 1.
- Word complete = accept while count == W-1.
  - count wraps to 0.
  - parallel_out <= {shift register[W-2:0], serial_in}.
  - parallel_out_valid <= 1.
  - Latency: parallel_out_valid rises the cycle after the last bit is accepted.
- out drain = parallel_out_valid & parallel_out_ready & clock_enable.
  - If drain occurs with no simultaneous word completion, parallel_out_valid <= 0 and parallel_out holds its value.
- Simultaneous drain and completion: parallel_out takes the new word and parallel_out_valid stays 1. Back-to-back words see no bubble.
- serial_in_ready = clock_enable & ~(count == W-1 & parallel_out_valid & ~parallel_out_ready).
  - The bit that would complete a word stalls only while the holding register is full and not draining.
  - Bits 0..W-2 of the next word are always accepted while the output is stalled.
  - This is a combinational path from parallel_out_ready to serial_in_ready; it is documented and intended.
- clock_enable low: serial_in_ready = 0. Shift register, count, parallel_out and parallel_out_valid hold. A parallel_out_ready pulse is ignored.
- No state machine beyond the count (0..W-1) and the holding-register valid flag. parallel_out changes only on word completion, clear or reset.
- serial_in_valid low mid-word: counter and shifter hold indefinitely; there is no timeout.

Test Plan (WORD_WIDTH = 8):
1. Single word: after reset, offer the bits of 0xA5 (1,0,1,0,0,1,0,1) on 8 consecutive cycles, parallel_out_ready = 0 -> serial_in_ready is high for all 8 cycles; parallel_out_valid rises the cycle after the 8th bit with parallel_out = 0xA5 and stays high.
2. Back-to-back with parallel_out_ready = 1: stream 0x3C then 0xC3 -> 16 consecutive accepts with serial_in_ready never low; parallel_out_valid is high for 0x3C, then 0xC3 the cycle after bit 16; valid then drops.
3. Backpressure: word 0x0F completes, parallel_out_ready = 0. Stream 7 bits of 0xF0 -> all accepted. The 8th bit sees serial_in_ready = 0. Raise parallel_out_ready -> same cycle, serial_in_ready = 1 and the bit is accepted; next cycle parallel_out = 0xF0 and valid stays 1.
4. Clock enable: after 3 bits of 0x96, drop clock_enable for 5 cycles while toggling serial_in_valid and serial_in -> serial_in_ready = 0 and no state change. Resume the remaining 5 bits -> parallel_out = 0x96.
5. Sync flush: after 3 bits, pulse clear with clock_enable = 0 -> count and valid return to 0. Then send 0x81 -> parallel_out = 0x81 with no leftover bits. Clear while valid = 1 -> valid = 0 on the next edge.
6. Async reset mid-word and with valid = 1: drop clear_n between clock edges -> parallel_out = 0 and parallel_out_valid = 0 immediately, with no edge. Release it, then send 0x55 -> parallel_out = 0x55.
